// File: rtl/convert_pipe_if.sv
// Handshake bundle for convert_pipe: an input sample stream and an output result stream.
// The master side is the producer of din and the consumer of dout; the slave side is the converter.
interface convert_pipe_if #(
  parameter int N_CHAN     = 1,
  parameter int N_BITS_IN  = 8,
  parameter int N_BITS_OUT = 4
);
  logic [N_CHAN*N_BITS_IN-1:0]  din;
  logic                         din_valid;
  logic                         din_ready;
  logic [N_CHAN*N_BITS_OUT-1:0] dout;
  logic                         dout_valid;
  logic                         dout_ready;
  logic [N_CHAN-1:0]            ovf;

  modport master (
    output din, din_valid, dout_ready,
    input  din_ready, dout, dout_valid, ovf
  );

  modport slave (
    input  din, din_valid, dout_ready,
    output din_ready, dout, dout_valid, ovf
  );
endinterface

// File: rtl/convert_pipe.sv
// convert_pipe: two-stage fixed-point format converter for N_CHAN channels in lockstep.
// Stage 1 aligns binary points and quantises. Stage 2 detects overflow, then saturates
// or wraps, and packs the result into the output register.
// Optional feature: define CONVERT_PIPE_OVF_CNT_EN to add a saturating 16-bit counter of
// delivered samples that had any overflow. The counter is exposed as ovf_cnt and cleared by
// ovf_cnt_clr.
module convert_pipe #(
  parameter int N_BITS_IN  = 8,
  parameter int BIN_PT_IN  = 7,
  parameter int N_BITS_OUT = 4,
  parameter int BIN_PT_OUT = 3,
  parameter int N_CHAN     = 1,
  parameter int SIGNED     = 1,
  parameter int QUANT      = 1,
  parameter int OVERFLOW   = 1
) (
  input  logic clk,
  input  logic rst_n,
  convert_pipe_if.slave bus
`ifdef CONVERT_PIPE_OVF_CNT_EN
  ,
  input  logic        ovf_cnt_clr,
  output logic [15:0] ovf_cnt
`endif
);

  // Shift needed to move from the input binary point to the output binary point.
  localparam int SH  = BIN_PT_IN - BIN_PT_OUT;
  localparam int LSH = (SH < 0) ? -SH : 0;
  localparam int RSH = (SH > 0) ? SH : 0;
  localparam int HSH = (RSH > 0) ? RSH - 1 : 0;

  // The working width covers the aligned input, the output range and the rounding half.
  // Two spare bits keep the sign and any rounding carry.
  localparam int WA = N_BITS_IN + LSH;
  localparam int WB = (N_BITS_OUT > RSH + 1) ? N_BITS_OUT : RSH + 1;
  localparam int W  = ((WA > WB) ? WA : WB) + 2;

  localparam int SBIT = (SIGNED != 0) ? 1 : 0;

  localparam logic signed [W-1:0] HALF     = (RSH > 0) ? (W'(1) << HSH) : '0;
  localparam logic        [W-1:0] REM_MASK = (W'(1) << RSH) - W'(1);
  localparam logic signed [W-1:0] MAXV     = (W'(1) << (N_BITS_OUT - SBIT)) - W'(1);
  localparam logic signed [W-1:0] MINV     = (SIGNED != 0) ? -(W'(1) << (N_BITS_OUT - 1)) : '0;

  logic                               s1_valid_q, s1_valid_d;
  logic [N_CHAN-1:0][W-1:0]           s1_data_q, s1_data_d;
  logic                               dout_valid_q, dout_valid_d;
  logic [N_CHAN*N_BITS_OUT-1:0]       dout_q, dout_d;
  logic [N_CHAN-1:0]                  ovf_q, ovf_d;

  logic [N_CHAN-1:0][W-1:0]           quant_c;
  logic [N_CHAN*N_BITS_OUT-1:0]       pack_c;
  logic [N_CHAN-1:0]                  ovf_c;
  logic                               s2_load;
  logic                               in_ready;

  // Stage 1 datapath: extend at the MSB end, align the binary point, then quantise the dropped LSBs.
  always_comb begin
    logic [N_BITS_IN-1:0] din_c;
    logic signed [W-1:0]  ext;
    logic signed [W-1:0]  aligned;
    logic signed [W-1:0]  trunc;
    logic        [W-1:0]  rem;
    din_c   = '0;
    ext     = '0;
    aligned = '0;
    trunc   = '0;
    rem     = '0;
    quant_c = '0;
    for (int unsigned c = 0; c < N_CHAN; c++) begin
      din_c = bus.din[c*N_BITS_IN +: N_BITS_IN];
      if (SIGNED != 0) ext = {{(W-N_BITS_IN){din_c[N_BITS_IN-1]}}, din_c};
      else             ext = {{(W-N_BITS_IN){1'b0}}, din_c};
      aligned = ext <<< LSH;
      trunc   = aligned >>> RSH;
      rem     = aligned & REM_MASK;
      if (QUANT == 1) begin
        quant_c[c] = (aligned + HALF) >>> RSH;
      end else if (QUANT == 2 && RSH > 0) begin
        if (rem > $unsigned(HALF) || (rem == $unsigned(HALF) && trunc[0]))
          quant_c[c] = trunc + W'(1);
        else
          quant_c[c] = trunc;
      end else begin
        quant_c[c] = trunc;
      end
    end
  end

  // Stage 2 datapath: range-check each quantised value, then clamp or wrap it into the output word.
  always_comb begin
    logic signed [W-1:0] qv;
    logic signed [W-1:0] val;
    qv     = '0;
    val    = '0;
    pack_c = '0;
    ovf_c  = '0;
    for (int unsigned c = 0; c < N_CHAN; c++) begin
      qv  = s1_data_q[c];
      val = qv;
      if (qv > MAXV) begin
        ovf_c[c] = 1'b1;
        if (OVERFLOW != 0) val = MAXV;
      end else if (qv < MINV) begin
        ovf_c[c] = 1'b1;
        if (OVERFLOW != 0) val = MINV;
      end
      pack_c[c*N_BITS_OUT +: N_BITS_OUT] = val[N_BITS_OUT-1:0];
    end
  end

  // Pipeline control: a stage loads only when its downstream slot is empty or is draining this cycle.
  always_comb begin
    s2_load      = !dout_valid_q || bus.dout_ready;
    in_ready     = s2_load || !s1_valid_q;
    s1_valid_d   = in_ready ? bus.din_valid : s1_valid_q;
    s1_data_d    = (in_ready && bus.din_valid) ? quant_c : s1_data_q;
    dout_valid_d = s2_load ? s1_valid_q : dout_valid_q;
    dout_d       = (s2_load && s1_valid_q) ? pack_c : dout_q;
    ovf_d        = (s2_load && s1_valid_q) ? ovf_c : ovf_q;
  end

  // Pipeline registers; reset empties both stages and clears the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_data_q    <= '0;
      dout_valid_q <= 1'b0;
      dout_q       <= '0;
      ovf_q        <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_data_q    <= s1_data_d;
      dout_valid_q <= dout_valid_d;
      dout_q       <= dout_d;
      ovf_q        <= ovf_d;
    end
  end

  assign bus.din_ready  = in_ready;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.ovf        = ovf_q;

`ifdef CONVERT_PIPE_OVF_CNT_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d;

  // Next count: clear has priority; otherwise count each delivered sample with any overflow, saturating.
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (ovf_cnt_clr)
      ovf_cnt_d = '0;
    else if (dout_valid_q && bus.dout_ready && (|ovf_q) && (ovf_cnt_q != '1))
      ovf_cnt_d = ovf_cnt_q + 16'd1;
  end

  // Overflow counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_cnt_q <= '0;
    else        ovf_cnt_q <= ovf_cnt_d;
  end

  assign ovf_cnt = ovf_cnt_q;
`endif

endmodule
